// File: rtl/prog_loader.sv
// prog_loader: streams a header-counted, little-endian program into the control unit.
// Optional checksum stage is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int inst_width = 32,
   parameter int inst_limit = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  start_i,
   input  logic                  rx_valid_i,
   input  logic [7:0]            rx_data_i,
   output logic                  rx_ready_o,
   output logic                  ctrl_reset_o,
   output logic                  load_o,
   output logic [inst_width-1:0] load_inst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);
   localparam int bpi = inst_width / 8;
   localparam int bcw = bpi > 1 ? $clog2(bpi) : 1;
   localparam logic [bcw-1:0] last_byte = bcw'(bpi - 1);
   localparam logic [15:0] limit = 16'(inst_limit);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLR    = 3'd1;
   localparam logic [2:0] S_HDR_LO = 3'd2;
   localparam logic [2:0] S_HDR_HI = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_CHK    = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_ERR    = 3'd7;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_LAST = S_CHK;
`else
   localparam logic [2:0] S_LAST = S_DONE;
`endif
   logic [2:0]            state_q, state_d;
   logic [15:0]           count_q, inst_cnt_q, hdr_count;
   logic [7:0]            hdr_lo_q;
   logic [bcw-1:0]        byte_cnt_q;
   logic [inst_width-1:0] shift_q, shift_d;
   logic                  acc, inst_done, last_inst;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif
   assign acc       = rx_valid_i && rx_ready_o;
   assign hdr_count = {rx_data_i, hdr_lo_q};
   assign inst_done = acc && state_q == S_DATA && byte_cnt_q == last_byte;
   assign last_inst = inst_cnt_q + 16'd1 == count_q;
   assign shift_d   = inst_width'({rx_data_i, shift_q} >> 8);
   // next-state selection; start is only honoured from the idle-like states
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: state_d = start_i ? S_CLR : state_q;
         S_CLR:    state_d = S_HDR_LO;
         S_HDR_LO: state_d = acc ? S_HDR_HI : state_q;
         S_HDR_HI: state_d = !acc ? state_q : (hdr_count == 16'd0 || hdr_count > limit) ? S_ERR : S_DATA;
         S_DATA:   state_d = (inst_done && last_inst) ? S_LAST : state_q;
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHK:    state_d = !acc ? state_q : (rx_data_i == csum_q) ? S_DONE : S_ERR;
`endif
         default:  state_d = S_IDLE;
      endcase
   end
   // state and status outputs registered from the next state
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         rx_ready_o   <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         ctrl_reset_o <= 1'b1;
      end else begin
         state_q      <= state_d;
         rx_ready_o   <= state_d inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CHK};
         busy_o       <= state_d inside {S_CLR, S_HDR_LO, S_HDR_HI, S_DATA, S_CHK};
         done_o       <= state_d == S_DONE;
         err_o        <= state_d == S_ERR;
         ctrl_reset_o <= state_d inside {S_IDLE, S_CLR, S_ERR};
      end
   end
   // header capture, byte assembly and instruction counting
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         hdr_lo_q   <= '0;
         count_q    <= '0;
         inst_cnt_q <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
      end else if (state_q == S_CLR) begin
         inst_cnt_q <= '0;
         byte_cnt_q <= '0;
      end else if (acc) begin
         if (state_q == S_HDR_LO) hdr_lo_q <= rx_data_i;
         if (state_q == S_HDR_HI) count_q <= hdr_count;
         if (state_q == S_DATA) begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_q == last_byte ? '0 : byte_cnt_q + 1'b1;
            inst_cnt_q <= inst_done ? inst_cnt_q + 16'd1 : inst_cnt_q;
         end
      end
   end
   // one-cycle load strobe with the completed instruction
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         load_o      <= 1'b0;
         load_inst_o <= '0;
      end else begin
         load_o      <= inst_done;
         load_inst_o <= inst_done ? shift_d : load_inst_o;
      end
   end
`ifdef PROG_LOADER_CHECKSUM_EN
   // running XOR over every data-phase byte
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) csum_q <= '0;
      else if (state_q == S_CLR) csum_q <= '0;
      else if (acc && state_q == S_DATA) csum_q <= csum_q ^ rx_data_i;
   end
`endif
endmodule
